// File: rtl/spi_phase_seq_pkg.sv
// Shared types for the SPI phase sequencer: FSM state encoding and the
// phase-index width helper.
package spi_phase_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_FIN,
    S_ERR
  } state_e;

  // Width of an index over n items, never narrower than one bit.
  function automatic int PHASE_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_phase_seq_timer.sv
// Per-phase watchdog for spi_phase_seq: cleared on phase launch, counts while
// the phase waits, flags expiry on the cycle the count reaches TIMEOUT-1.
module spi_phase_seq_timer
  import spi_phase_seq_pkg::*;
#(
  parameter int TIMEOUT = 27_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = PHASE_W(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign o_expired = i_enable && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && !o_expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_phase_seq.sv
// Sequences NUM_PHASES client blocks onto one SPI panel link: launches each
// client in turn, muxes its SPI lines, optionally loops back to LOOP_FROM.
// Define SPI_PHASE_SEQ_TIMEOUT_EN to compile in the per-phase watchdog.
module spi_phase_seq
  import spi_phase_seq_pkg::*;
#(
  parameter int NUM_PHASES = 3,
  parameter int LOOP_FROM  = NUM_PHASES - 1,
  parameter int TIMEOUT    = 27_000_000
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_go,
  input  logic                           i_repeat,
  input  logic                           i_abort,
  input  logic [NUM_PHASES-1:0]          i_done,
  input  logic [NUM_PHASES-1:0]          i_mosi,
  input  logic [NUM_PHASES-1:0]          i_dc,
  input  logic [NUM_PHASES-1:0]          i_cs,
  output logic [NUM_PHASES-1:0]          o_start,
  output logic                           o_mosi,
  output logic                           o_dc,
  output logic                           o_cs,
  output logic [PHASE_W(NUM_PHASES)-1:0] o_phase,
  output logic                           o_busy,
  output logic                           o_fin,
  output logic                           o_err
);

  localparam int PW = PHASE_W(NUM_PHASES);
  localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_PHASES - 1);
  localparam logic [PW-1:0] LOOP_PHASE = PW'(LOOP_FROM);

  if (NUM_PHASES < 1 || NUM_PHASES > 16 || LOOP_FROM < 0 ||
      LOOP_FROM >= NUM_PHASES || TIMEOUT < 1) begin : g_bad_cfg
    $error("spi_phase_seq: parameter out of range");
  end

  state_e                state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [NUM_PHASES-1:0] start_q, start_d;
  logic                  busy_q;
  logic                  fin_q;
  logic                  expired;

`ifdef SPI_PHASE_SEQ_TIMEOUT_EN
  logic err_q;

  spi_phase_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (state_q == S_LAUNCH),
    .i_enable  (state_q == S_WAIT),
    .o_expired (expired)
  );

  assign o_err = err_q;
`else
  assign expired = 1'b0;
  assign o_err   = 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    phase_d = phase_q;
    start_d = '0;
    if (i_abort) begin
      state_d = S_IDLE;
      phase_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_FIN, S_ERR: begin
          if (i_go) begin
            state_d = S_LAUNCH;
            phase_d = '0;
          end
        end
        S_LAUNCH: begin
          start_d[phase_q] = 1'b1;
          state_d          = S_WAIT;
        end
        S_WAIT: begin
          // A done in the expiry cycle still advances normally.
          if (i_done[phase_q]) begin
            if (phase_q != LAST_PHASE) begin
              phase_d = phase_q + 1'b1;
              state_d = S_LAUNCH;
            end else if (i_repeat) begin
              phase_d = LOOP_PHASE;
              state_d = S_LAUNCH;
            end else begin
              state_d = S_FIN;
            end
          end else if (expired) begin
            state_d = S_ERR;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      start_q <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
`ifdef SPI_PHASE_SEQ_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      start_q <= start_d;
      busy_q  <= (state_d == S_LAUNCH) || (state_d == S_WAIT);
      fin_q   <= (state_d == S_FIN);
`ifdef SPI_PHASE_SEQ_TIMEOUT_EN
      err_q   <= (state_d == S_ERR);
`endif
    end
  end

  // The panel sees the selected client only while a phase is live; idle bus is CS high.
  assign o_mosi  = busy_q ? i_mosi[phase_q] : 1'b0;
  assign o_dc    = busy_q ? i_dc[phase_q]   : 1'b0;
  assign o_cs    = busy_q ? i_cs[phase_q]   : 1'b1;
  assign o_start = start_q;
  assign o_phase = phase_q;
  assign o_busy  = busy_q;
  assign o_fin   = fin_q;

endmodule

// File: tb/tb_spi_phase_seq.sv
// Directed self-checking bench for spi_phase_seq (3 phases, TIMEOUT=16).
// The watchdog scenario runs only when SPI_PHASE_SEQ_TIMEOUT_EN is defined.
module tb_spi_phase_seq;

  localparam int NP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          go, rep, abort;
  logic [NP-1:0] done, mosi, dc, cs;
  logic [NP-1:0] o_start;
  logic          o_mosi, o_dc, o_cs, o_busy, o_fin, o_err;
  logic [1:0]    o_phase;

  int errors = 0;
  int checks = 0;

  spi_phase_seq #(
    .NUM_PHASES (NP),
    .TIMEOUT    (16)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_go     (go),
    .i_repeat (rep),
    .i_abort  (abort),
    .i_done   (done),
    .i_mosi   (mosi),
    .i_dc     (dc),
    .i_cs     (cs),
    .o_start  (o_start),
    .o_mosi   (o_mosi),
    .o_dc     (o_dc),
    .o_cs     (o_cs),
    .o_phase  (o_phase),
    .o_busy   (o_busy),
    .o_fin    (o_fin),
    .o_err    (o_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the next start pulse, then compare it against the expected one-hot.
  task automatic wait_start(input int idx, input string name);
    int n = 0;
    logic [NP-1:0] exp_start;
    exp_start = NP'(1) << idx;
    while (o_start == '0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (o_start !== exp_start) begin
      errors++;
      $display("FAIL %s: o_start=%b expected %b", name, o_start, exp_start);
    end
  endtask

  task automatic pulse_done(input int idx);
    done      = '0;
    done[idx] = 1'b1;
    tick();
    done      = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 0; rep = 0; abort = 0;
    done = '0; mosi = '1; dc = '1; cs = '0;
    tick();
    tick();
    checks++; if (o_start !== 3'b000) begin errors++; $display("FAIL reset_start: got %b expected 000", o_start); end
    checks++; if (o_phase !== 2'd0)   begin errors++; $display("FAIL reset_phase: got %0d expected 0", o_phase); end
    checks++; if ({o_busy, o_fin, o_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: busy/fin/err=%b expected 000", {o_busy, o_fin, o_err}); end
    checks++; if ({o_cs, o_mosi, o_dc} !== 3'b100) begin errors++; $display("FAIL reset_bus: cs/mosi/dc=%b expected 100", {o_cs, o_mosi, o_dc}); end
    rst = 1'b0;
    tick();
    checks++; if (o_start !== 3'b000 || o_busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: start=%b busy=%b expected 000/0", o_start, o_busy); end
  endtask

  task automatic test_sequence();
    cs = '0; mosi = '0; dc = '0;
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++; if (o_busy !== 1'b1 || o_phase !== 2'd0 || o_start !== 3'b000) begin
      errors++; $display("FAIL seq_launch: busy=%b phase=%0d start=%b expected 1/0/000", o_busy, o_phase, o_start); end
    for (int p = 0; p < NP; p++) begin
      wait_start(p, "seq_start");
      tick();
      checks++; if (o_start !== 3'b000) begin errors++; $display("FAIL seq_pulse_width: phase %0d start=%b expected 000", p, o_start); end
      checks++; if (o_cs !== 1'b0) begin errors++; $display("FAIL seq_cs_pass: phase %0d cs=%b expected 0", p, o_cs); end
      repeat (4) tick();
      pulse_done(p);
      if (p < NP - 1) begin
        checks++; if (o_phase !== 2'(p + 1) || o_start !== 3'b000) begin
          errors++; $display("FAIL seq_advance: phase=%0d start=%b expected %0d/000", o_phase, o_start, p + 1); end
        tick();
        checks++; if (o_start !== (NP'(1) << (p + 1))) begin
          errors++; $display("FAIL seq_latency: start=%b expected %b", o_start, NP'(1) << (p + 1)); end
      end else begin
        checks++; if (o_fin !== 1'b1 || o_busy !== 1'b0 || o_cs !== 1'b1 || o_phase !== 2'd2) begin
          errors++; $display("FAIL seq_fin: fin=%b busy=%b cs=%b phase=%0d expected 1/0/1/2", o_fin, o_busy, o_cs, o_phase); end
      end
    end
  endtask

  task automatic test_repeat();
    rep = 1'b1;
    go  = 1'b1;
    tick();
    go  = 1'b0;
    checks++; if (o_fin !== 1'b0 || o_phase !== 2'd0) begin errors++; $display("FAIL rep_go_from_fin: fin=%b phase=%0d expected 0/0", o_fin, o_phase); end
    wait_start(0, "rep_start0");
    pulse_done(0);
    wait_start(1, "rep_start1");
    pulse_done(1);
    wait_start(2, "rep_start2");
    pulse_done(2);
    checks++; if (o_phase !== 2'd2 || o_start !== 3'b000 || o_busy !== 1'b1) begin
      errors++; $display("FAIL rep_loop: phase=%0d start=%b busy=%b expected 2/000/1", o_phase, o_start, o_busy); end
    tick();
    checks++; if (o_start !== 3'b100) begin errors++; $display("FAIL rep_restart: start=%b expected 100", o_start); end
    rep = 1'b0;
    pulse_done(2);
    checks++; if (o_fin !== 1'b1) begin errors++; $display("FAIL rep_fin: fin=%b expected 1", o_fin); end
    repeat (3) tick();
    checks++; if (o_fin !== 1'b1 || o_phase !== 2'd2 || o_start !== 3'b000) begin
      errors++; $display("FAIL fin_hold: fin=%b phase=%0d start=%b expected 1/2/000", o_fin, o_phase, o_start); end
  endtask

  task automatic test_mux();
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_start(0, "mux_start0");
    pulse_done(0);
    wait_start(1, "mux_start1");
    cs = 3'b101; mosi = 3'b010; dc = 3'b010;
    #1;
    checks++; if ({o_cs, o_mosi, o_dc} !== 3'b011) begin errors++; $display("FAIL mux_phase1: cs/mosi/dc=%b expected 011", {o_cs, o_mosi, o_dc}); end
    cs = 3'b010;
    #1;
    checks++; if (o_cs !== 1'b1) begin errors++; $display("FAIL mux_comb: cs=%b expected 1", o_cs); end
    cs = 3'b101;
    done = 3'b100;
    go = 1'b1;
    repeat (3) tick();
    done = '0;
    go = 1'b0;
    checks++; if (o_phase !== 2'd1 || o_start !== 3'b000 || o_busy !== 1'b1 || o_cs !== 1'b0) begin
      errors++; $display("FAIL mux_stray_done: phase=%0d start=%b busy=%b cs=%b expected 1/000/1/0", o_phase, o_start, o_busy, o_cs); end
    pulse_done(1);
    wait_start(2, "mux_start2");
  endtask

  task automatic test_abort();
    abort = 1'b1;
    done  = 3'b100;
    tick();
    abort = 1'b0;
    done  = '0;
    checks++; if (o_busy !== 1'b0 || o_phase !== 2'd0 || o_fin !== 1'b0 || o_mosi !== 1'b0 || o_cs !== 1'b1) begin
      errors++; $display("FAIL abort_wait: busy=%b phase=%0d fin=%b mosi=%b cs=%b expected 0/0/0/0/1", o_busy, o_phase, o_fin, o_mosi, o_cs); end
    tick();
    checks++; if (o_start !== 3'b000 || o_busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: start=%b busy=%b expected 000/0", o_start, o_busy); end
    go = 1'b1;
    tick();
    go = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (o_start !== 3'b000 || o_busy !== 1'b0) begin errors++; $display("FAIL abort_launch: start=%b busy=%b expected 000/0", o_start, o_busy); end
  endtask

  task automatic test_reset_mid();
    cs = '0; mosi = '1; dc = '1;
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_start(0, "rstm_start0");
    pulse_done(0);
    wait_start(1, "rstm_start1");
    tick();
    rst = 1'b1;
    #1;
    checks++; if (o_busy !== 1'b0 || o_phase !== 2'd0 || o_start !== 3'b000 || {o_cs, o_mosi, o_dc} !== 3'b100) begin
      errors++; $display("FAIL reset_async: busy=%b phase=%0d start=%b cs/mosi/dc=%b expected 0/0/000/100", o_busy, o_phase, o_start, {o_cs, o_mosi, o_dc}); end
    #3;
    rst = 1'b0;
    tick();
    checks++; if (o_start !== 3'b000 || o_busy !== 1'b0) begin errors++; $display("FAIL reset_release: start=%b busy=%b expected 000/0", o_start, o_busy); end
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_start(0, "rstm_clean0");
    pulse_done(0);
    wait_start(1, "rstm_clean1");
    pulse_done(1);
    wait_start(2, "rstm_clean2");
    pulse_done(2);
    checks++; if (o_fin !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL reset_clean_fin: fin=%b busy=%b expected 1/0", o_fin, o_busy); end
  endtask

`ifdef SPI_PHASE_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_start(0, "to_start");
    repeat (15) tick();
    checks++; if (o_err !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL timeout_early: err=%b busy=%b expected 0/1", o_err, o_busy); end
    tick();
    checks++; if (o_err !== 1'b1 || o_busy !== 1'b0 || o_phase !== 2'd0) begin
      errors++; $display("FAIL timeout_err: err=%b busy=%b phase=%0d expected 1/0/0", o_err, o_busy, o_phase); end
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++; if (o_err !== 1'b0 || o_busy !== 1'b1 || o_phase !== 2'd0) begin
      errors++; $display("FAIL timeout_restart: err=%b busy=%b phase=%0d expected 0/1/0", o_err, o_busy, o_phase); end
    wait_start(0, "to_restart_start");
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_repeat();
    test_mux();
    test_abort();
    test_reset_mid();
`ifdef SPI_PHASE_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_idle: err=%b expected 0", o_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/spi_phase_seq.md
SPI_PHASE_SEQ -- requirements
Module: spi_phase_seq

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 3: number of client phase blocks (init, clear, draw, ...), range 1..16.
REQ-002 SHALL have parameter LOOP_FROM, default NUM_PHASES-1: phase index re-entered in repeat mode, range 0..NUM_PHASES-1.
REQ-003 SHALL have parameter TIMEOUT, default 27_000_000: maximum cycles a phase may stay in WAIT.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 i_clk  in  1  system clock; all state on its rising edge.
REQ-006 i_rst  in  1  asynchronous active-high reset.
REQ-007 i_go  in  1  start sequence from phase 0; honoured only in IDLE, FIN or ERR.
REQ-008 i_repeat  in  1  sampled on last-phase done: 1 = loop back to LOOP_FROM.
REQ-009 i_abort  in  1  return to IDLE from any state.
REQ-010 i_done  in  NUM_PHASES  per-phase done level/pulse from clients.
REQ-011 i_mosi, i_dc, i_cs  in  NUM_PHASES each  per-phase SPI lines from clients.
REQ-012 o_start  out  NUM_PHASES  one-hot single-cycle start pulse to a client.
REQ-013 o_mosi, o_dc, o_cs  out  1 each  muxed SPI lines to the panel.
REQ-014 o_phase  out  max(1,$clog2(NUM_PHASES))  currently selected phase.
REQ-015 o_busy  out  1  high in LAUNCH or WAIT.
REQ-016 o_fin  out  1  high in FIN.
REQ-017 o_err  out  1  high in ERR.

Function
REQ-018 FSM states SHALL be IDLE, LAUNCH, WAIT, FIN, ERR.
REQ-019 IDLE/FIN/ERR + i_go SHALL go to LAUNCH next cycle with o_phase=0.
REQ-020 LAUNCH SHALL assert o_start[o_phase] for exactly one cycle, then go to WAIT.
REQ-021 WAIT SHALL sample only i_done[o_phase]; other i_done bits and i_done during LAUNCH SHALL be ignored.
REQ-022 WAIT + done, o_phase<NUM_PHASES-1: o_phase+1, go to LAUNCH.
REQ-023 WAIT + done, last phase, i_repeat=1: o_phase<=LOOP_FROM, go to LAUNCH; i_repeat=0: go to FIN.
REQ-024 Done-to-next-o_start latency SHALL be 2 cycles (WAIT->LAUNCH->pulse visible).
REQ-025 In LAUNCH/WAIT o_mosi/o_dc/o_cs SHALL equal i_mosi/i_dc/i_cs[o_phase] combinationally; otherwise o_mosi=0, o_dc=0, o_cs=1.
REQ-026 i_abort SHALL override every other event in the same cycle: next state IDLE, o_phase=0, no o_start.
REQ-027 i_go while busy SHALL be ignored.
REQ-028 FIN and ERR SHALL hold until i_go or i_abort.
REQ-029 o_phase SHALL hold its last value in FIN and ERR (diagnostic).

Reset
REQ-030 On i_rst: state IDLE, o_phase=0, o_start=0, o_busy=0, o_fin=0, o_err=0, o_cs=1, o_mosi=0, o_dc=0, timer=0.
REQ-031 Reset mid-phase SHALL take effect asynchronously; no o_start pulse on the first cycle after release.

Configuration
REQ-032 Macro SPI_PHASE_SEQ_TIMEOUT_EN SHALL compile in the watchdog.
REQ-033 With it: timer clears in LAUNCH, counts in WAIT; reaching TIMEOUT-1 without done -> ERR next cycle; done in that same cycle wins (normal advance).
REQ-034 Without it: no timer logic, o_err tied 0, WAIT never times out, TIMEOUT unused.

Structure
REQ-035 Package spi_phase_seq_pkg SHALL hold the state enum and PHASE_W width function.
REQ-036 Watchdog SHALL be sub-module spi_phase_seq_timer (clear, enable, expired), instantiated only under the macro.

Verification
REQ-037 NUM_PHASES=3, i_go, each client done 5 cycles after its start -> o_start pulses 0,1,2 in order, o_fin=1, o_cs=1 after.
REQ-038 Repeat: i_repeat=1, LOOP_FROM=2 -> after phase 2 done, o_start[2] again 2 cycles later; clear i_repeat -> FIN.
REQ-039 Mux: phase 1 active, i_cs=3'b101 -> o_cs=0; stray i_done[2]=1 -> no advance.
REQ-040 Abort and i_done[o_phase] same cycle -> IDLE, o_phase=0, o_busy=0.
REQ-041 TIMEOUT_EN, TIMEOUT=16, no done -> o_err=1 exactly 16 WAIT cycles after start; i_go -> restart at phase 0.
REQ-042 i_rst asserted in WAIT of phase 1 -> all outputs at reset values immediately; i_go after release -> clean sequence from phase 0.
